// File: rtl/decoder_rr_arbiter_if.sv
// Request/grant bundle for the 8-way round-robin arbiter.
// Requester n drives req[7-n] and owns grant[7-n].
interface decoder_rr_arbiter_if;
    logic [7:0] req;
    logic [7:0] grant;
    logic [2:0] grant_idx;
    logic       grant_valid;
    logic       timeout;

    modport master (
        output req,
        input  grant,
        input  grant_idx,
        input  grant_valid,
        input  timeout
    );

    modport slave (
        input  req,
        output grant,
        output grant_idx,
        output grant_valid,
        output timeout
    );
endinterface

// File: rtl/decoder_rr_arbiter.sv
// 8-way round-robin arbiter with registered one-hot grant and owner index.
// Optional forced revoke after HOLD_MAX grant cycles: define ARB_TIMEOUT_EN.
module decoder_rr_arbiter #(
    parameter int HOLD_MAX = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    decoder_rr_arbiter_if.slave  bus
);

`ifdef ARB_TIMEOUT_EN
    typedef enum logic [1:0] {IDLE, GRANT, REVOKE} state_t;
`else
    typedef enum logic [1:0] {IDLE, GRANT} state_t;
`endif

    // Reject illegal hold limits at elaboration.
    if (HOLD_MAX < 2 || HOLD_MAX > 255) begin : g_bad_hold_max
        $error("decoder_rr_arbiter: HOLD_MAX out of range 2..255");
    end

    state_t     r_state;
    state_t     w_state_nxt;
    logic [2:0] r_ptr;
    logic [2:0] w_ptr_nxt;
    logic [2:0] r_idx;
    logic [2:0] w_idx_nxt;
    logic       r_valid;
    logic       w_valid_nxt;
    logic [7:0] r_grant;
    logic [7:0] w_grant_nxt;
    logic       r_timeout;
    logic       w_timeout_nxt;
    logic [7:0] w_req_n;
    logic       w_found;
    logic [2:0] w_win;
    logic [2:0] w_cand;

`ifdef ARB_TIMEOUT_EN
    logic [7:0] r_hold;
    logic [7:0] w_hold_nxt;
`endif

    // Re-index the request vector by requester number.
    always_comb begin
        w_req_n = '0;
        for (int n = 0; n < 8; n++) begin
            w_req_n[n] = bus.req[7-n];
        end
    end

    // Pick the first requester after the last owner, wrapping 7 -> 0.
    always_comb begin
        w_found = 1'b0;
        w_win   = r_ptr;
        w_cand  = r_ptr;
        for (int k = 1; k <= 8; k++) begin
            w_cand = r_ptr + 3'(k);
            if (!w_found && w_req_n[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end
    end

    // Next state and next registered outputs.
    always_comb begin
        w_state_nxt   = r_state;
        w_ptr_nxt     = r_ptr;
        w_idx_nxt     = r_idx;
        w_valid_nxt   = r_valid;
        w_timeout_nxt = 1'b0;
`ifdef ARB_TIMEOUT_EN
        w_hold_nxt    = r_hold;
`endif
        unique case (r_state)
            IDLE: begin
                w_idx_nxt   = 3'd0;
                w_valid_nxt = 1'b0;
                if (w_found) begin
                    w_state_nxt = GRANT;
                    w_ptr_nxt   = w_win;
                    w_idx_nxt   = w_win;
                    w_valid_nxt = 1'b1;
`ifdef ARB_TIMEOUT_EN
                    w_hold_nxt  = 8'd0;
`endif
                end
            end
            GRANT: begin
                if (!w_req_n[r_idx]) begin
                    w_state_nxt = IDLE;
                    w_idx_nxt   = 3'd0;
                    w_valid_nxt = 1'b0;
                end
`ifdef ARB_TIMEOUT_EN
                else if (r_hold == 8'(HOLD_MAX - 1)) begin
                    w_state_nxt   = REVOKE;
                    w_idx_nxt     = 3'd0;
                    w_valid_nxt   = 1'b0;
                    w_timeout_nxt = 1'b1;
                end else if (r_hold != 8'hFF) begin
                    w_hold_nxt = r_hold + 8'd1;
                end
`endif
            end
`ifdef ARB_TIMEOUT_EN
            REVOKE: begin
                w_state_nxt = IDLE;
                w_idx_nxt   = 3'd0;
                w_valid_nxt = 1'b0;
            end
`endif
            default: begin
                w_state_nxt = IDLE;
                w_idx_nxt   = 3'd0;
                w_valid_nxt = 1'b0;
            end
        endcase
        w_grant_nxt = w_valid_nxt ? (8'h80 >> w_idx_nxt) : 8'h00;
    end

    // State and output registers; reset overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_ptr     <= 3'd7;
            r_idx     <= 3'd0;
            r_valid   <= 1'b0;
            r_grant   <= 8'h00;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ptr     <= w_ptr_nxt;
            r_idx     <= w_idx_nxt;
            r_valid   <= w_valid_nxt;
            r_grant   <= w_grant_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

`ifdef ARB_TIMEOUT_EN
    // Hold counter for the current owner.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hold <= 8'd0;
        end else begin
            r_hold <= w_hold_nxt;
        end
    end
`endif

    assign bus.grant       = r_grant;
    assign bus.grant_idx   = r_idx;
    assign bus.grant_valid = r_valid;
    assign bus.timeout     = r_timeout;

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Scenario bench for decoder_rr_arbiter: expected output words are queued
// as each cycle is driven and popped once the DUT has registered them.
module tb_decoder_rr_arbiter;

`ifdef ARB_TIMEOUT_EN
    localparam int HM = 4;
`else
    localparam int HM = 16;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    logic [12:0] sb[$];
    logic [12:0] got;
    logic [12:0] exp_w;

    decoder_rr_arbiter_if bus();

    decoder_rr_arbiter #(.HOLD_MAX(HM)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // {grant, grant_idx, grant_valid, timeout}; -1 idle, 8 timeout pulse.
    function automatic logic [12:0] ex(input int n);
        logic [7:0] g;
        if (n < 0) return 13'h0;
        if (n == 8) return 13'h1;
        g = 8'h80 >> n;
        return {g, 3'(n), 1'b1, 1'b0};
    endfunction

    task automatic cycle(input logic r, input logic [7:0] q, input int e);
        rst = r;
        bus.req = q;
        sb.push_back(ex(e));
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic       rs[$] = '{1'b1, 1'b1, 1'b0};
        logic [7:0] rq[$] = '{8'h00, 8'hFF, 8'h00};
        int         ev[$] = '{-1, -1, -1};
        for (int i = 0; i < rq.size(); i++) begin
            cycle(rs[i], rq[i], ev[i]);
            got = {bus.grant, bus.grant_idx, bus.grant_valid, bus.timeout};
            exp_w = sb.pop_front();
            checks++;
            if (got !== exp_w) begin
                failures++;
                $display("FAIL reset step %0d got=%h exp=%h", i, got, exp_w);
            end
        end
    endtask

    task automatic test_single();
        logic       rs[$] = '{1'b1, 1'b0, 1'b0, 1'b0};
        logic [7:0] rq[$] = '{8'h00, 8'h20, 8'h20, 8'h00};
        int         ev[$] = '{-1, 2, 2, -1};
        for (int i = 0; i < rq.size(); i++) begin
            cycle(rs[i], rq[i], ev[i]);
            got = {bus.grant, bus.grant_idx, bus.grant_valid, bus.timeout};
            exp_w = sb.pop_front();
            checks++;
            if (got !== exp_w) begin
                failures++;
                $display("FAIL single step %0d got=%h exp=%h", i, got, exp_w);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic       rs[$] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [7:0] rq[$] = '{8'h00, 8'h20, 8'h00, 8'h20, 8'h00, 8'h20};
        int         ev[$] = '{-1, 2, -1, 2, -1, 2};
        for (int i = 0; i < rq.size(); i++) begin
            cycle(rs[i], rq[i], ev[i]);
            got = {bus.grant, bus.grant_idx, bus.grant_valid, bus.timeout};
            exp_w = sb.pop_front();
            checks++;
            if (got !== exp_w) begin
                failures++;
                $display("FAIL b2b step %0d got=%h exp=%h", i, got, exp_w);
            end
        end
    endtask

    task automatic test_rotation();
        logic       rs[$];
        logic [7:0] rq[$];
        int         ev[$];
        logic [7:0] m;
        rs.push_back(1'b1); rq.push_back(8'h00); ev.push_back(-1);
        for (int n = 0; n < 8; n++) begin
            m = 8'h80 >> n;
            rs.push_back(1'b0); rq.push_back(8'hFF); ev.push_back(n);
            rs.push_back(1'b0); rq.push_back(8'hFF); ev.push_back(n);
            rs.push_back(1'b0); rq.push_back(8'hFF & ~m); ev.push_back(-1);
        end
        rs.push_back(1'b0); rq.push_back(8'hFF); ev.push_back(0);
        for (int i = 0; i < rq.size(); i++) begin
            cycle(rs[i], rq[i], ev[i]);
            got = {bus.grant, bus.grant_idx, bus.grant_valid, bus.timeout};
            exp_w = sb.pop_front();
            checks++;
            if (got !== exp_w) begin
                failures++;
                $display("FAIL rotation step %0d got=%h exp=%h", i, got, exp_w);
            end
        end
    endtask

    task automatic test_wrap();
        logic       rs[$] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [7:0] rq[$] = '{8'h00, 8'h01, 8'h80, 8'h81, 8'h81};
        int         ev[$] = '{-1, 7, -1, 0, 0};
        for (int i = 0; i < rq.size(); i++) begin
            cycle(rs[i], rq[i], ev[i]);
            got = {bus.grant, bus.grant_idx, bus.grant_valid, bus.timeout};
            exp_w = sb.pop_front();
            checks++;
            if (got !== exp_w) begin
                failures++;
                $display("FAIL wrap step %0d got=%h exp=%h", i, got, exp_w);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic       rs[$] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [7:0] rq[$] = '{8'h00, 8'h04, 8'h04, 8'h04, 8'hFF, 8'hFF, 8'hFF};
        int         ev[$] = '{-1, 5, 5, -1, -1, 0, 0};
        for (int i = 0; i < rq.size(); i++) begin
            cycle(rs[i], rq[i], ev[i]);
            got = {bus.grant, bus.grant_idx, bus.grant_valid, bus.timeout};
            exp_w = sb.pop_front();
            checks++;
            if (got !== exp_w) begin
                failures++;
                $display("FAIL reset_mid step %0d got=%h exp=%h", i, got, exp_w);
            end
        end
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        logic       rs[$] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [7:0] rq[$] = '{8'h00, 8'h41, 8'h41, 8'h41, 8'h41, 8'h41, 8'h41, 8'h41};
        int         ev[$] = '{-1, 1, 1, 1, 1, 8, -1, 7};
        for (int i = 0; i < rq.size(); i++) begin
            cycle(rs[i], rq[i], ev[i]);
            got = {bus.grant, bus.grant_idx, bus.grant_valid, bus.timeout};
            exp_w = sb.pop_front();
            checks++;
            if (got !== exp_w) begin
                failures++;
                $display("FAIL timeout step %0d got=%h exp=%h", i, got, exp_w);
            end
        end
    endtask
`else
    task automatic test_hold();
        cycle(1'b1, 8'h00, -1);
        got = {bus.grant, bus.grant_idx, bus.grant_valid, bus.timeout};
        exp_w = sb.pop_front();
        checks++;
        if (got !== exp_w) begin
            failures++;
            $display("FAIL hold reset got=%h exp=%h", got, exp_w);
        end
        for (int i = 0; i < 300; i++) begin
            cycle(1'b0, 8'h04, 5);
            got = {bus.grant, bus.grant_idx, bus.grant_valid, bus.timeout};
            exp_w = sb.pop_front();
            checks++;
            if (got !== exp_w) begin
                failures++;
                $display("FAIL hold step %0d got=%h exp=%h", i, got, exp_w);
            end
        end
    endtask
`endif

    initial begin
        bus.req = 8'h00;
        rst = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_single();
        test_back_to_back();
        test_rotation();
        test_wrap();
        test_reset_mid();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`else
        test_hold();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/decoder_rr_arbiter.md
DECODER_RR_ARBITER -- requirements
Module: decoder_rr_arbiter

Interface
REQ-001 Parameter HOLD_MAX, default 16: maximum consecutive grant cycles per owner; legal range 2..255; used only with ARB_TIMEOUT_EN.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 req  input  8  request vector; requester n drives bit (7-n).
REQ-005 grant  output  8  one-hot grant; requester n owns bit (7-n); all-zero when no owner.
REQ-006 grant_idx  output  3  binary index of current owner; 3'd0 when grant_valid low.
REQ-007 grant_valid  output  1  high while any grant is active.
REQ-008 timeout  output  1  one-cycle pulse when a grant is forcibly revoked.

Function
REQ-009 All outputs SHALL be registered; no combinational path from req to any output.
REQ-010 FSM states: IDLE, GRANT, REVOKE.
REQ-011 IDLE: if req nonzero at edge N, select winner, enter GRANT; grant/grant_idx/grant_valid valid after edge N (visible in cycle N+1); else stay IDLE.
REQ-012 Winner: first requester with request set, searching indices ptr+1, ptr+2, ... mod 8, wrapping 7->0, where ptr is the last granted index.
REQ-013 ptr SHALL update to the winner index at the same edge the grant is issued; ptr unchanged while idle.
REQ-014 grant SHALL equal the decode of grant_idx: idx 0 -> 8'b10000000 ... idx 7 -> 8'b00000001.
REQ-015 GRANT: held unchanged while owner's request bit stays high; other requests ignored.
REQ-016 GRANT: owner's request low at edge N -> grant, grant_idx, grant_valid cleared after edge N; enter IDLE; earliest next grant after edge N+1 (one mandatory gap cycle).
REQ-017 Owner re-requesting in IDLE competes normally; it has lowest priority (searched last) if others request.
REQ-018 Single requester repeatedly requesting SHALL be re-granted after each gap cycle.
REQ-019 Simultaneous release by owner and new requests at edge N: release wins; new requests evaluated in IDLE at edge N+1.
REQ-020 REVOKE (only with ARB_TIMEOUT_EN): grant cleared, timeout pulse high for exactly one cycle; exits to IDLE next edge regardless of req.
REQ-021 Hold counter: 8 bits, cleared on grant issue, increments each GRANT cycle; saturates, never wraps.

Reset
REQ-022 rst high at any edge, including mid-GRANT or REVOKE: state=IDLE, grant=8'h00, grant_idx=3'd0, grant_valid=0, timeout=0, hold counter=0, ptr=3'd7 (first search starts at index 0).
REQ-023 rst has priority over all other inputs; no grant issued in the cycle after a reset edge.

Configuration
REQ-024 Macro ARB_TIMEOUT_EN defined: GRANT with hold counter reaching HOLD_MAX-1 and owner still requesting -> next edge enter REVOKE; ptr stays at revoked owner so it is searched last.
REQ-025 Macro ARB_TIMEOUT_EN undefined: no hold counter, no REVOKE state; grant held indefinitely while owner requests; timeout tied to 0.

Verification
REQ-026 Reset, then req=8'b00100000 (requester 2) -> one cycle later grant=8'b00100000, grant_idx=2, grant_valid=1.
REQ-027 req=8'hFF held, each owner drops its bit for one cycle after 2 grant cycles -> grant order 0,1,2,...,7,0 with one gap cycle between grants.
REQ-028 Owner 7 releases while req=8'b10000001 -> after gap cycle grant=8'b10000000 (wrap to index 0).
REQ-029 ARB_TIMEOUT_EN, HOLD_MAX=4, req=8'b01000001 held -> requester 1 granted 4 cycles, timeout pulse 1 cycle, gap, then requester 7 granted.
REQ-030 rst asserted during grant to requester 5 -> all outputs zero after that edge; after release, req=8'hFF -> requester 0 granted first.
REQ-031 Without ARB_TIMEOUT_EN, req=8'b00000100 held 300 cycles -> grant to requester 5 constant, timeout never high.
